// File: rtl/pipe_ripple_add.sv
// Pipelined ripple-carry adder/subtractor, one WIDTH/STAGES-bit slice per stage; PIPE_RIPPLE_ADD_SAT_EN adds saturation.
// Latency: STAGES cycles from accept edge to output transfer edge; one result per cycle when unstalled.
// Backpressure: per-stage valid bits with collapsing bubbles; in_ready drops only when every stage is full and out_ready is low.
module pipe_ripple_add #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SL   = WIDTH / STAGES;
  localparam int MSB  = WIDTH - 1;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;
  logic [WIDTH-1:0]  b_eff;
  logic              c_first;

  // Subtraction is A + ~B + 1, so the inversion and forced carry happen before stage 0.
  assign b_eff   = sub ? ~b : b;
  assign c_first = sub | cin;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stg
      logic             src_v;
      logic [WIDTH-1:0] src_a;
      logic [WIDTH-1:0] src_b;
      logic [WIDTH-1:0] src_s;
      logic             src_c;
      logic [WIDTH-1:0] nxt_s;
      logic             nxt_c;
      logic             v_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;
      logic             c_q;

      if (k == 0) begin : g_src
        assign src_v = in_valid;
        assign src_a = a;
        assign src_b = b_eff;
        assign src_s = '0;
        assign src_c = c_first;
      end else begin : g_src
        assign src_v = g_stg[k-1].v_q;
        assign src_a = g_stg[k-1].a_q;
        assign src_b = g_stg[k-1].b_q;
        assign src_s = g_stg[k-1].s_q;
        assign src_c = g_stg[k-1].c_q;
      end

      // A stage can load if it, or any stage between it and the output, has a free slot.
      assign ld[k]  = out_ready || !(&vld[LAST:k]);
      assign vld[k] = v_q;

      always_comb begin
        logic c;
        c     = src_c;
        nxt_s = src_s;
        for (int i = 0; i < SL; i++) begin
          nxt_s[k*SL+i] = src_a[k*SL+i] ^ src_b[k*SL+i] ^ c;
          c = (src_a[k*SL+i] & src_b[k*SL+i]) | (c & (src_a[k*SL+i] ^ src_b[k*SL+i]));
        end
        nxt_c = c;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
        end else if (ld[k]) begin
          v_q <= src_v;
          if (src_v) begin
            a_q <= src_a;
            b_q <= src_b;
            s_q <= nxt_s;
            c_q <= nxt_c;
          end
        end
      end
    end
  endgenerate

  logic [WIDTH-1:0] s_last;
  logic             a_msb;
  logic             b_msb;
  logic             unused_operand_lsbs;

  assign s_last    = g_stg[LAST].s_q;
  assign a_msb     = g_stg[LAST].a_q[MSB];
  assign b_msb     = g_stg[LAST].b_q[MSB];
  assign unused_operand_lsbs = ^{g_stg[LAST].a_q[MSB-1:0], g_stg[LAST].b_q[MSB-1:0]};

  assign in_ready  = ld[0];
  assign out_valid = vld[LAST];
  assign cout      = g_stg[LAST].c_q;
  assign ovf       = (a_msb == b_msb) && (s_last[MSB] != a_msb);

`ifdef PIPE_RIPPLE_ADD_SAT_EN
  always_comb begin
    sum = s_last;
    if (ovf) sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign sum = s_last;
`endif

endmodule
